div_ratio_detect: RTL
=====================

Name: div_ratio_detect

Overview:
- Receive-side checker for the clock-divider family. Samples a divided clock, `div_in`, in the `clk` domain.
- Measures its period and high time in `clk` cycles and flags when the measured period is stable.
- Compares the stable period against an expected divide ratio.
- Sits beside the divider outputs as a self-test/monitor: divider drives `div_in`, software or bench reads `period`/`locked`/`match`.

Parameters:
- CNT_W, 8, width of period/high-time counters and outputs.
- SYNC_STAGES, 2, flop stages on `div_in` before edge detection (min 2).
- LOCK_COUNT, 4, consecutive equal periods required to assert `locked` (1..15).

Ports:
- clk  input  1  system clock; all logic posedge.
- reset  input  1  synchronous active-low reset.
- div_in  input  1  divided clock under test, treated as asynchronous.
- exp_ratio  input  CNT_W  expected period in clk cycles; quasi-static.
- period  output  CNT_W  last measured rising-to-rising interval, in clk cycles.
- high_time  output  CNT_W  sampled high cycles within that interval.
- valid  output  1  one-cycle pulse when `period`/`high_time` update.
- locked  output  1  LOCK_COUNT consecutive identical periods seen.
- match  output  1  locked && (period == exp_ratio).
- stall  output  1  no rising edge for 2^CNT_W-1 cycles; level.
- VDD  inout  1  power pin, no logic.
- VSS  inout  1  ground pin, no logic.

Behaviour:
- Reset: clock and reset as already decided — one clock, `clk`; `reset` is synchronous and active-low.
  - While `reset`=0 at a posedge, all outputs go to 0, all counters go to 0, sync flops go to 0, and the FSM goes to IDLE.
- Sync/edge: `s` = last sync stage; `rise` = `s` & ~`s_d` (`s_d` = `s` delayed one cycle); combinational.
- FSM states:
  - IDLE: wait for `s`=0, then go to ARM. This blocks a false edge when `div_in` is high at reset release.
  - ARM: on `rise`, set `per_cnt`<=1 and `hi_cnt`<=1, then go to MEAS. No valid is emitted.
  - MEAS:
    - Each non-rise cycle: `per_cnt`+=1; `hi_cnt`+=1 if `s`=1.
    - On `rise`: `period`<=`per_cnt`, `high_time`<=`hi_cnt`, `valid`<=1 next cycle, then `per_cnt`<=1 and `hi_cnt`<=1.
- Latency: `div_in` rising edge to `valid` high is SYNC_STAGES+1 clk cycles, plus 0–1 cycles of sampling uncertainty.
- Resolution: period >= 2 is required. A 50% odd divider yields an exact period; `high_time` is floor or ceil of N/2, depending on phase.
- Lock:
  - On each valid, if the new period equals the previous period, `stable_cnt`+=1, saturating at LOCK_COUNT; otherwise `stable_cnt`<=0 and `locked`<=0.
  - `locked`<=1 when `stable_cnt` reaches LOCK_COUNT.
  - The first valid after ARM counts as a mismatch (no previous period).
- match: registered; updates the same cycle as `locked`/`period`; 0 whenever `locked`=0.
- Timeout: in ARM or MEAS, if `per_cnt`==all-ones and no `rise`:
  - `stall`<=1, `locked`<=0, `stable_cnt`<=0, FSM goes to IDLE.
  - `period` and `high_time` hold their last values.
  - `stall` clears on the next `rise` seen in ARM.
- Simultaneous rise and timeout in the same cycle: `rise` wins and the measurement completes normally.
- Change of `exp_ratio`: affects `match` the next cycle only; lock state is unaffected.
- Reset mid-measurement: the partial count is discarded and the next valid requires a fresh IDLE→ARM→MEAS sequence.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ARM, MEAS} (2-bit);
  - CNT_W default;
  - the saturating-counter max constant.
- One sub-module, `sync_edge_det`:
  - SYNC_STAGES flop chain plus previous-value flop;
  - outputs `s` and `rise`;
  - uses the same synchronous active-low reset.

Test Plan:
- Div-by-9, 50% duty (both-edge divider model), exp_ratio=9 -> valids every 9 cycles; period=9; high_time in {4,5}; locked and match high at the 5th valid.
- Div-by-12, exp_ratio=9 -> period=12, high_time=6, locked=1, match=0; change exp_ratio to 12 -> match=1 next cycle.
- div_in held high through reset release, then toggled at /8 -> no valid until after the first genuine low; first valid period=8.
- Locked at /9, then switch div_in to /10 -> locked drops on the first valid with period=10; relocks after 4 more equal periods.
- div_in stuck low with CNT_W=8 -> stall=1 exactly 255 cycles after the last rise count started; period holds 9; restart toggling -> stall clears at the first rise.
- Reset pulsed mid-MEAS at /9 -> all outputs 0 the next cycle; resumes with period=9 valids and no spurious short period.

Source files
------------

// File: rtl/div_ratio_detect_pkg.sv
// -----------------------------------------------------------------------------
// div_ratio_detect_pkg
// Shared types and constants for the divided-clock ratio checker.
//   state_t  : measurement FSM state (IDLE, ARM, MEAS)
//   CNT_W_DEF: default width of the period / high-time counters
//   cnt_max  : all-ones value of a counter of the given width; the period
//              counter reaching it without an edge means the input stalled
// -----------------------------------------------------------------------------
package div_ratio_detect_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/div_ratio_detect_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings the asynchronous divided clock into the clk domain and detects its
// rising edge.
//   clk   : system clock, posedge
//   reset : synchronous active-low reset
//   din   : asynchronous input
//   s     : synchronised level (last flop of the chain)
//   rise  : s high while its previous value was low (combinational)
//   ready : s carries a real sample rather than a reset-cleared zero
// -----------------------------------------------------------------------------
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic s,
  output logic rise,
  output logic ready
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   s_d;

  // A valid bit travels alongside each sample so the FSM can tell a genuine
  // low apart from the zeros that reset leaves in the chain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, exactly like real hardware.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      vld_q  <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s     = sync_q[SYNC_STAGES-1];
  assign rise  = s & ~s_d;
  assign ready = vld_q[SYNC_STAGES-1];

endmodule

// File: rtl/div_ratio_detect.sv
// -----------------------------------------------------------------------------
// div_ratio_detect
// Receive-side monitor for a divided clock. Measures the rising-to-rising
// period and the high time of div_in in clk cycles, flags a stable period and
// compares it with the expected divide ratio.
//   clk       : system clock, posedge
//   reset     : synchronous active-low reset
//   div_in    : divided clock under test, asynchronous
//   exp_ratio : expected period in clk cycles, quasi-static
//   period    : last measured period
//   high_time : sampled high cycles within that period
//   valid     : one-cycle pulse when period/high_time update
//   locked    : LOCK_COUNT consecutive identical periods seen
//   match     : locked and period equals exp_ratio
//   stall     : no rising edge for 2^CNT_W-1 cycles (level)
//   VDD/VSS   : power pins, no logic
// -----------------------------------------------------------------------------
module div_ratio_detect
  import div_ratio_detect_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_ratio,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             match,
  output logic             stall,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_COUNT);

  logic s, rise, ready;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (div_in),
    .s     (s),
    .rise  (rise),
    .ready (ready)
  );

  // Power pins carry no logic; tie them into a sink so they are not dangling.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  state_t           state, state_n;
  logic [CNT_W-1:0] per_cnt, per_n;
  logic [CNT_W-1:0] hi_cnt, hi_n;
  logic [CNT_W-1:0] period_n, high_n;
  logic [3:0]       stable_cnt, stable_n;
  logic             have_prev, have_prev_n;
  logic             valid_n, locked_n, stall_n;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    per_n       = per_cnt;
    hi_n        = hi_cnt;
    period_n    = period;
    high_n      = high_time;
    stable_n    = stable_cnt;
    have_prev_n = have_prev;
    valid_n     = 1'b0;
    locked_n    = locked;
    stall_n     = stall;

    unique case (state)
      IDLE: begin
        // Wait for a genuine low so a level that is already high at reset
        // release is never mistaken for a rising edge.
        if (ready && !s) begin
          state_n = ARM;
          per_n   = CNT_ONE;
          hi_n    = '0;
        end
      end

      ARM: begin
        if (rise) begin
          state_n     = MEAS;
          per_n       = CNT_ONE;
          hi_n        = CNT_ONE;
          stall_n     = 1'b0;
          have_prev_n = 1'b0;
        end else if (per_cnt == CNT_MAX) begin
          state_n  = IDLE;
          stall_n  = 1'b1;
          locked_n = 1'b0;
          stable_n = '0;
        end else begin
          per_n = per_cnt + CNT_ONE;
        end
      end

      MEAS: begin
        // A rise in the same cycle as the counter saturating still completes
        // the measurement.
        if (rise) begin
          period_n = per_cnt;
          high_n   = hi_cnt;
          valid_n  = 1'b1;
          per_n    = CNT_ONE;
          hi_n     = CNT_ONE;
          if (have_prev && per_cnt == period) begin
            stable_n = (stable_cnt == LOCK_MAX) ? stable_cnt : stable_cnt + 4'd1;
            locked_n = (stable_n == LOCK_MAX);
          end else begin
            stable_n = '0;
            locked_n = 1'b0;
          end
          have_prev_n = 1'b1;
        end else if (per_cnt == CNT_MAX) begin
          state_n  = IDLE;
          stall_n  = 1'b1;
          locked_n = 1'b0;
          stable_n = '0;
        end else begin
          per_n = per_cnt + CNT_ONE;
          hi_n  = hi_cnt + {{(CNT_W-1){1'b0}}, s};
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      period     <= '0;
      high_time  <= '0;
      stable_cnt <= '0;
      have_prev  <= 1'b0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      match      <= 1'b0;
      stall      <= 1'b0;
    end else begin
      state      <= state_n;
      per_cnt    <= per_n;
      hi_cnt     <= hi_n;
      period     <= period_n;
      high_time  <= high_n;
      stable_cnt <= stable_n;
      have_prev  <= have_prev_n;
      valid      <= valid_n;
      locked     <= locked_n;
      stall      <= stall_n;
      // Built from the next-state values so match moves together with
      // locked/period, and follows exp_ratio one cycle later.
      match      <= locked_n && (period_n == exp_ratio);
    end
  end

endmodule
